// File: rtl/petris_pkg.sv
// Shared button indices, widths and repeat-state encoding for the petris input path.
package petris_pkg;

  localparam int unsigned NUM_BUTTONS = 5;

  localparam int unsigned RIGHT  = 0;
  localparam int unsigned LEFT   = 1;
  localparam int unsigned DOWN   = 2;
  localparam int unsigned ROTATE = 3;
  localparam int unsigned START  = 4;

  // Movement buttons RIGHT..DOWN occupy the low indices and are the only ones that repeat.
  localparam int unsigned NUM_RPT = DOWN + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchroniser, counter debouncer and registered press pulse.
module button_debounce
  import petris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 125000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          press_q, press_d;

  // Press pulse is aligned with the first cycle the accepted level reads 1.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    press_d = 1'b0;
    if (sync_q == acc_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      acc_d   = sync_q;
      cnt_d   = '0;
      press_d = sync_q;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      press_q <= press_d;
    end
  end

  assign level_o = acc_q;
  assign press_o = press_q;

endmodule

// File: rtl/input_conditioner.sv
// Raw buttons -> frame-aligned operation vector; auto-repeat for RIGHT/LEFT/DOWN
// is built only when INPUT_AUTOREPEAT_EN is defined.
module input_conditioner
  import petris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 125000,
  parameter int unsigned DAS_FRAMES      = 10,
  parameter int unsigned ARR_FRAMES      = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  input  logic                   vsync,
  output logic [NUM_BUTTONS-1:0] operation,
  output logic                   frame_tick
);

  logic [NUM_BUTTONS-1:0] btn_level;
  logic [NUM_BUTTONS-1:0] btn_press;
  logic [NUM_BUTTONS-1:0] rpt_c;
  logic [NUM_BUTTONS-1:0] frame_vec_c;
  logic [NUM_BUTTONS-1:0] pend_q, pend_d;
  logic [NUM_BUTTONS-1:0] op_q, op_d;
  logic                   tick_q;
  logic                   vs_meta_q, vs_sync_q, vs_prev_q;
  logic                   tick_c;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock   (clock),
      .reset   (reset),
      .btn_i   (buttons_raw[i]),
      .level_o (btn_level[i]),
      .press_o (btn_press[i])
    );
  end

  assign tick_c = vs_sync_q & ~vs_prev_q;

`ifdef INPUT_AUTOREPEAT_EN
  localparam int unsigned RCW = cnt_width((DAS_FRAMES > ARR_FRAMES) ? DAS_FRAMES : ARR_FRAMES);
  localparam logic [RCW-1:0] DAS_LAST = RCW'(DAS_FRAMES - 1);
  localparam logic [RCW-1:0] ARR_LAST = RCW'(ARR_FRAMES - 1);

  rpt_state_e     rpt_q  [NUM_RPT];
  rpt_state_e     rpt_d  [NUM_RPT];
  logic [RCW-1:0] rcnt_q [NUM_RPT];
  logic [RCW-1:0] rcnt_d [NUM_RPT];
  logic           unused_level;

  assign unused_level = ^btn_level[NUM_BUTTONS-1:NUM_RPT];

  // Release forces IDLE ahead of any same-cycle tick; counters saturate.
  always_comb begin
    rpt_c = '0;
    for (int unsigned i = 0; i < NUM_RPT; i++) begin
      rpt_d[i]  = rpt_q[i];
      rcnt_d[i] = rcnt_q[i];
      if (!btn_level[i]) begin
        rpt_d[i]  = IDLE;
        rcnt_d[i] = '0;
      end else begin
        case (rpt_q[i])
          IDLE: begin
            if (btn_press[i]) begin
              rpt_d[i]  = DELAY;
              rcnt_d[i] = '0;
            end
          end
          DELAY: begin
            if (tick_c) begin
              if (rcnt_q[i] == DAS_LAST) begin
                rpt_c[i]  = 1'b1;
                rpt_d[i]  = REPEAT;
                rcnt_d[i] = '0;
              end else if (rcnt_q[i] != '1) begin
                rcnt_d[i] = rcnt_q[i] + RCW'(1);
              end
            end
          end
          REPEAT: begin
            if (tick_c) begin
              if (rcnt_q[i] == ARR_LAST) begin
                rpt_c[i]  = 1'b1;
                rcnt_d[i] = '0;
              end else if (rcnt_q[i] != '1) begin
                rcnt_d[i] = rcnt_q[i] + RCW'(1);
              end
            end
          end
          default: begin
            rpt_d[i]  = IDLE;
            rcnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_RPT; i++) begin
        rpt_q[i]  <= IDLE;
        rcnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_RPT; i++) begin
        rpt_q[i]  <= rpt_d[i];
        rcnt_q[i] <= rcnt_d[i];
      end
    end
  end
`else
  logic unused_level;

  assign rpt_c        = '0;
  assign unused_level = ^{btn_level, 32'(DAS_FRAMES), 32'(ARR_FRAMES)};
`endif

  // Frame vector: sticky presses plus anything arriving in the tick cycle itself.
  always_comb begin
    frame_vec_c = pend_q | btn_press | rpt_c;
    if (frame_vec_c[RIGHT] && frame_vec_c[LEFT]) begin
      frame_vec_c[RIGHT] = 1'b0;
      frame_vec_c[LEFT]  = 1'b0;
    end
    pend_d = pend_q | btn_press;
    op_d   = op_q;
    if (tick_c) begin
      pend_d = '0;
      op_d   = frame_vec_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
      vs_prev_q <= 1'b0;
      tick_q    <= 1'b0;
      pend_q    <= '0;
      op_q      <= '0;
    end else begin
      vs_meta_q <= vsync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
      tick_q    <= tick_c;
      pend_q    <= pend_d;
      op_q      <= op_d;
    end
  end

  assign operation  = op_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner; repeat expectations follow INPUT_AUTOREPEAT_EN.
module tb_input_conditioner;

  localparam int DEB       = 4;
  localparam int DAS       = 3;
  localparam int ARR       = 2;
  localparam int FRAME_LEN = 40;
  localparam int VS_AT     = 8;
  localparam int VS_LEN    = 5;
  localparam int NEVER     = -10;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] buttons_raw;
  logic       vsync;
  logic [4:0] operation;
  logic       frame_tick;

  logic [4:0] held;
  int         n_checks = 0;
  int         n_fail   = 0;

  typedef struct {
    logic [4:0] press;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs [9];

  always #5 clock = ~clock;

  input_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .DAS_FRAMES      (DAS),
    .ARR_FRAMES      (ARR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .buttons_raw (buttons_raw),
    .vsync       (vsync),
    .operation   (operation),
    .frame_tick  (frame_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One vsync period; returns the operation loaded at its frame_tick.
  task automatic run_frame(input logic [4:0] set_mask, input int set_at,
                           input logic [4:0] clr_mask, input int clr_at,
                           input logic [4:0] bmask, input int rst_at,
                           output logic [4:0] op);
    int         ticks;
    logic       changed;
    logic [4:0] prev;
    ticks   = 0;
    changed = 1'b0;
    op      = '0;
    prev    = operation;
    for (int c = 0; c < FRAME_LEN; c++) begin
      if (c == set_at) held = held | set_mask;
      if (c == clr_at) held = held & ~clr_mask;
      buttons_raw = held;
      if (bmask != 5'b0 && c >= 12 && c < 32)
        buttons_raw = ((((c - 12) >> 1) % 2) == 0) ? (held | bmask) : (held & ~bmask);
      vsync = (c >= VS_AT) && (c < VS_AT + VS_LEN);
      reset = (c >= rst_at) && (c < rst_at + 2);
      @(negedge clock);
      if (frame_tick === 1'b1) begin
        ticks++;
        op = operation;
      end else if (operation !== prev) begin
        changed = 1'b1;
      end
      prev = operation;
    end
    check("tick_count", 32'(ticks), 32'd1);
    check("op_stable", 32'(changed), 32'd0);
  endtask

  initial begin
    logic [4:0] op;
    logic [4:0] prev_exp;
    logic [4:0] exp;

    vecs[0] = '{press: 5'b00001, exp: 5'b00001};
    vecs[1] = '{press: 5'b00011, exp: 5'b00000};
    vecs[2] = '{press: 5'b00010, exp: 5'b00010};
    vecs[3] = '{press: 5'b01000, exp: 5'b01000};
    vecs[4] = '{press: 5'b10000, exp: 5'b10000};
    vecs[5] = '{press: 5'b00100, exp: 5'b00100};
    vecs[6] = '{press: 5'b11111, exp: 5'b11100};
    vecs[7] = '{press: 5'b00000, exp: 5'b00000};
    vecs[8] = '{press: 5'b01110, exp: 5'b01110};

    held        = '0;
    buttons_raw = '0;
    vsync       = 1'b0;
    reset       = 1'b1;
    repeat (2) @(negedge clock);
    check("reset_op", 32'(operation), 32'd0);
    check("reset_tick", 32'(frame_tick), 32'd0);

    for (int f = 0; f < 3; f++) begin
      run_frame(5'b0, NEVER, 5'b0, NEVER, 5'b0, NEVER, op);
      check($sformatf("idle_frame%0d", f), 32'(op), 32'd0);
    end

    // Clean press/release within a frame shows up in the following frame.
    prev_exp = '0;
    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i].press, 20, vecs[i].press, 28, 5'b0, NEVER, op);
      check($sformatf("vec%0d_prev", i), 32'(op), 32'(prev_exp));
      prev_exp = vecs[i].exp;
    end
    run_frame(5'b0, NEVER, 5'b0, NEVER, 5'b0, NEVER, op);
    check("vec8", 32'(op), 32'(prev_exp));

    // Bounce on ROTATE, then hold: exactly one frame with the bit.
    run_frame(5'b01000, 32, 5'b0, NEVER, 5'b01000, NEVER, op);
    check("bounce_f0", 32'(op), 32'd0);
    run_frame(5'b0, NEVER, 5'b01000, 20, 5'b0, NEVER, op);
    check("bounce_f1", 32'(op), 32'b01000);
    run_frame(5'b0, NEVER, 5'b0, NEVER, 5'b0, NEVER, op);
    check("bounce_f2", 32'(op), 32'd0);

    // Reset after a mid-frame press discards it.
    run_frame(5'b01000, 14, 5'b01000, 20, 5'b0, 32, op);
    check("rst_mid_f0", 32'(op), 32'd0);
    run_frame(5'b0, NEVER, 5'b0, NEVER, 5'b0, NEVER, op);
    check("rst_mid_f1", 32'(op), 32'd0);

    // Press event lands in the tick cycle: only that frame carries it.
    run_frame(5'b10000, 4, 5'b10000, 14, 5'b0, NEVER, op);
    check("coincide_f0", 32'(op), 32'b10000);
    run_frame(5'b0, NEVER, 5'b0, NEVER, 5'b0, NEVER, op);
    check("coincide_f1", 32'(op), 32'd0);

    // Hold DOWN for 10 frames starting with a tick-cycle press, release mid-frame.
    run_frame(5'b00100, 4, 5'b0, NEVER, 5'b0, NEVER, op);
    check("rpt_f0", 32'(op), 32'b00100);
    for (int k = 1; k <= 12; k++) begin
      run_frame(5'b0, NEVER, 5'b00100, (k == 9) ? 20 : NEVER, 5'b0, NEVER, op);
`ifdef INPUT_AUTOREPEAT_EN
      exp = ((k == 3) || (k == 5) || (k == 7) || (k == 9)) ? 5'b00100 : 5'b00000;
`else
      exp = 5'b00000;
`endif
      check($sformatf("rpt_f%0d", k), 32'(op), 32'(exp));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
